dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the MEM stage of the 5-stage pipeline.
//  - Takes MemRead/MemWrite requests issued from the EX->MEM pipeline register.
//  - Serves each request after a fixed multi-cycle latency.
//  - Holds the pipeline with stall_o while a request is in flight.
//  - Returns read data to the MEM->WB pipeline register.
// PARAMETERS
//  DEPTH_WORDS  256  number of 32-bit words; power of 2; IDX_W = log2(DEPTH_WORDS)
//  LATENCY      3    cycles from request acceptance to response; legal range 1..15
// PORTS
//  clk_i        in   1   clock; all state changes on posedge
//  rst_i        in   1   reset; asynchronous, active-high
//  MemRead_i    in   1   load request from the EX->MEM pipeline register
//  MemWrite_i   in   1   store request from the EX->MEM pipeline register
//  addr_i       in   32  byte address (ALUResult)
//  wdata_i      in   32  store data (RS2data)
//  be_i         in   4   byte enables; present only with DMEM_BYTE_STROBE_EN
//  rdata_o      out  32  load data; valid while done_o=1, then held
//  stall_o      out  1   freeze PC, IF->ID, ID->EX and EX->MEM; hold MEM->WB
//  done_o       out  1   one-cycle response pulse
//  err_o        out  1   error flag, qualified by done_o
// BEHAVIOUR
//  Reset: async, active-high.
//   - Forces state=IDLE, cnt=0, rdata_o=0, stall_o=0, done_o=0, err_o=0.
//   - Does not clear the memory array.
//  FSM: IDLE -> BUSY -> RESP -> IDLE.
//  IDLE
//   - A request is MemRead_i|MemWrite_i.
//   - On a request, stall_o=1 combinationally in the same cycle.
//   - At the edge: latch op/addr/wdata(/be), set cnt=LATENCY-1, go BUSY.
//  BUSY
//   - stall_o=1.
//   - cnt decrements each cycle.
//   - In the cycle with cnt==0 the access is performed at the edge, then go RESP.
//   - Write: mem[addr[IDX_W+1:2]] <= wdata.
//   - Read: rdata_o <= mem[addr[IDX_W+1:2]].
//  RESP
//   - stall_o=0, done_o=1 for exactly one cycle.
//   - The pipeline advances at the end of this cycle; go IDLE.
//   - The request visible in RESP is never re-accepted.
//   - A new request is accepted in the following IDLE cycle.
//  Latency: acceptance edge to done_o = LATENCY+1 cycles; back-to-back requests every LATENCY+2 cycles.
//  Address arithmetic:
//   - Word index = addr_i[IDX_W+1:2]; upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
//   - Misaligned access (addr[1:0]!=0): no memory access; rdata_o=0; err_o=1 in RESP.
//  Both MemRead_i and MemWrite_i set:
//   - Treated as a write.
//   - err_o=1 in RESP.
//  Reset mid-operation: the in-flight access is aborted and the write is not committed; return to IDLE.
//  rdata_o updates only on reads; writes and errors keep its previous value (misaligned reads give 0).
// CONFIGURATION
//  DMEM_BYTE_STROBE_EN defined:
//   - be_i port exists.
//   - A write updates only the bytes whose be_i bit is set.
//   - be_i==0 is a no-op write: no error, done_o still pulses.
//  DMEM_BYTE_STROBE_EN undefined:
//   - No be_i port.
//   - Every write updates all 4 bytes.
// STRUCTURE
//  Package dmem_pkg:
//   - FSM state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2).
//   - Default DEPTH_WORDS / LATENCY constants.
//   - Counter width CNT_W=4.
//  Sub-module dmem_array: single-port sync read/write RAM.
//   - Ports: clk, we, be, idx, wdata, rdata.
//   - Instantiated once.
//  FSM, counter and latches live in dmem_responder.
// TESTING
//  1 Reset: assert rst_i mid-cycle -> all outputs 0 immediately; stall_o=0 with no request.
//  2 Write 0xDEADBEEF to 0x10, then read 0x10 (LATENCY=3):
//     - stall_o high 4 cycles per request.
//     - done_o pulses 1 cycle.
//     - Read returns rdata_o=0xDEADBEEF; err_o=0.
//  3 Wrap: write 0x12345678 to 0x400 (DEPTH_WORDS=256) -> read of 0x0 returns 0x12345678.
//  4 Misaligned read at 0x13 -> err_o=1 with done_o; rdata_o=0; memory unchanged.
//  5 rst_i pulse during BUSY of a write of 0xA5A5A5A5 to 0x20:
//     - FSM returns to IDLE.
//     - Later read of 0x20 returns the old value.
//  6 With DMEM_BYTE_STROBE_EN:
//     - Write 0xFFFFFFFF with be_i=4'b0101 over 0x00000000 -> read gives 0x00FF00FF.
//     - Without the macro, the same write gives 0xFFFFFFFF.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants for the MEM-stage data-memory responder: FSM encoding,
// default geometry/latency and the latency counter width.
package dmem_pkg;

  localparam int DMEM_DEPTH_WORDS = 256;
  localparam int DMEM_LATENCY     = 3;
  localparam int CNT_W            = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with synchronous read and per-byte write enables.
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // NOTE: the storage array has no reset; clearing it would force flops
  // instead of a RAM macro, and the pipeline never relies on its contents.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we && be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: fixed-latency load/store with pipeline stall.
// Define DMEM_BYTE_STROBE_EN to add the be_i byte-enable port.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter int LATENCY     = DMEM_LATENCY
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]  be_i,
`endif
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;
  logic             wr_q;
  logic             misal_q;
  logic             both_q;
  logic [31:0]      rdata_q;
  logic [31:0]      arr_rdata;
  logic             arr_we;
  logic             req;
  logic [3:0]       be_in;
  logic             unused_addr_hi;

  assign req            = MemRead_i | MemWrite_i;
  assign unused_addr_hi = ^addr_i[31:IDX_W+2];

`ifdef DMEM_BYTE_STROBE_EN
  assign be_in = be_i;
`else
  assign be_in = 4'hF;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (req) begin
          state <= ST_BUSY;
          cnt   <= CNT_W'(LATENCY - 1);
        end
        ST_BUSY: begin
          if (cnt == '0) state <= ST_RESP;
          else           cnt   <= cnt - 1'b1;
        end
        ST_RESP: begin
          state <= ST_IDLE;
          if (!wr_q) rdata_q <= misal_q ? 32'h0 : arr_rdata;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: request capture registers carry no reset; they are only consumed
  // after an acceptance edge has loaded them, so reset value is irrelevant.
  always_ff @(posedge clk_i) begin
    if (state == ST_IDLE && req) begin
      idx_q   <= addr_i[IDX_W+1:2];
      wdata_q <= wdata_i;
      be_q    <= be_in;
      wr_q    <= MemWrite_i;
      both_q  <= MemRead_i & MemWrite_i;
      misal_q <= is_misaligned(addr_i[1:0]);
    end
  end

  // The access fires on the final BUSY edge; reset drops state so an
  // in-flight write is never committed.
  assign arr_we = (state == ST_BUSY) && (cnt == '0) && wr_q && !misal_q;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk_i),
    .we   (arr_we),
    .be   (be_q),
    .idx  (idx_q),
    .wdata(wdata_q),
    .rdata(arr_rdata)
  );

  assign stall_o = (state == ST_BUSY) || (state == ST_IDLE && req);
  assign done_o  = (state == ST_RESP);
  assign err_o   = done_o && (misal_q || both_q);

  // Read data is presented straight from the RAM in RESP and held afterwards.
  assign rdata_o = (done_o && !wr_q) ? (misal_q ? 32'h0 : arr_rdata) : rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH_WORDS=256, LATENCY=3).
module tb_dmem_responder;

  localparam int LAT = 3;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        MemRead_i = 1'b0;
  logic        MemWrite_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [3:0]  be_i = 4'hF;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        done_o;
  logic        err_o;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_responder #(
    .DEPTH_WORDS(256),
    .LATENCY    (LAT)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .MemRead_i (MemRead_i),
    .MemWrite_i(MemWrite_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
`ifdef DMEM_BYTE_STROBE_EN
    .be_i      (be_i),
`endif
    .rdata_o   (rdata_o),
    .stall_o   (stall_o),
    .done_o    (done_o),
    .err_o     (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request at a negedge, hold it until the response cycle, then drop it.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int  stalls = 0;
    int  cyc    = 0;
    bit  seen   = 0;
    @(negedge clk_i);
    MemRead_i = rd; MemWrite_i = wr; addr_i = a; wdata_i = wd; be_i = be;
    #1;
    check({tag, "_stall_now"}, {31'b0, stall_o}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      if (stall_o) stalls++;
      if (done_o) begin
        seen = 1;
        cyc  = i;
        break;
      end
      @(negedge clk_i); #1;
    end
    check({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
    if (seen) begin
      check({tag, "_latency"}, cyc, LAT + 1);
      check({tag, "_stall_cycles"}, stalls, LAT + 1);
      check({tag, "_err"}, {31'b0, err_o}, {31'b0, exp_err});
      check({tag, "_rdata"}, rdata_o, exp_rdata);
    end
    MemRead_i = 1'b0; MemWrite_i = 1'b0;
    @(negedge clk_i); #1;
    check({tag, "_done_pulse"}, {31'b0, done_o}, 32'd0);
    check({tag, "_idle_stall"}, {31'b0, stall_o}, 32'd0);
    check({tag, "_rdata_hold"}, rdata_o, exp_rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset asserted asynchronously, away from any clock edge.
    #2 rst_i = 1'b1;
    #1;
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_stall", {31'b0, stall_o}, 32'd0);
    check("rst_done",  {31'b0, done_o}, 32'd0);
    check("rst_err",   {31'b0, err_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i); #1;
    check("idle_no_req_stall", {31'b0, stall_o}, 32'd0);

    access("wr10",  1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0);
    access("rd10",  1'b1, 1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADBEEF, 1'b0);
    access("wr400", 1'b0, 1'b1, 32'h400, 32'h12345678, 4'hF, 32'hDEADBEEF, 1'b0);
    access("rd0",   1'b1, 1'b0, 32'h0,   32'h0,        4'hF, 32'h12345678, 1'b0);
    access("rd13",  1'b1, 1'b0, 32'h13,  32'h0,        4'hF, 32'h0,        1'b1);
    access("rd10b", 1'b1, 1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADBEEF, 1'b0);
    access("wr20",  1'b0, 1'b1, 32'h20,  32'h11111111, 4'hF, 32'hDEADBEEF, 1'b0);

    // Abort a write with reset while it is still counting down.
    @(negedge clk_i);
    MemWrite_i = 1'b1; addr_i = 32'h20; wdata_i = 32'hA5A5A5A5; be_i = 4'hF;
    @(negedge clk_i); #1;
    check("abort_busy_stall", {31'b0, stall_o}, 32'd1);
    @(negedge clk_i); #1;
    rst_i = 1'b1; MemWrite_i = 1'b0;
    #1;
    check("abort_rst_stall", {31'b0, stall_o}, 32'd0);
    check("abort_rst_done",  {31'b0, done_o}, 32'd0);
    check("abort_rst_err",   {31'b0, err_o}, 32'd0);
    check("abort_rst_rdata", rdata_o, 32'h0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i); #1;
    check("abort_idle_stall", {31'b0, stall_o}, 32'd0);
    check("abort_idle_done",  {31'b0, done_o}, 32'd0);

    access("rd20",   1'b1, 1'b0, 32'h20, 32'h0,        4'hF, 32'h11111111, 1'b0);
    access("both30", 1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 32'h11111111, 1'b1);
    access("rd30",   1'b1, 1'b0, 32'h30, 32'h0,        4'hF, 32'hCAFEF00D, 1'b0);
    access("wr40z",  1'b0, 1'b1, 32'h40, 32'h00000000, 4'hF, 32'hCAFEF00D, 1'b0);
    access("wr40be", 1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'b0101, 32'hCAFEF00D, 1'b0);
`ifdef DMEM_BYTE_STROBE_EN
    access("rd40",   1'b1, 1'b0, 32'h40, 32'h0,        4'hF, 32'h00FF00FF, 1'b0);
    access("wr40b0", 1'b0, 1'b1, 32'h40, 32'h12345678, 4'b0000, 32'h00FF00FF, 1'b0);
    access("rd40b",  1'b1, 1'b0, 32'h40, 32'h0,        4'hF, 32'h00FF00FF, 1'b0);
`else
    access("rd40",   1'b1, 1'b0, 32'h40, 32'h0,        4'hF, 32'hFFFFFFFF, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
